// File: rtl/cnn_mac_rr_sched_if.sv
// Bus bundle for cnn_mac_rr_sched: requester beats, shared-multiplier operands/product, result stream.
// master is the environment side (PE lanes, shared multiplier, result sink); slave is the scheduler.
interface cnn_mac_rr_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int A_W     = 14,
    parameter int B_W     = 7,
    parameter int P_W     = 21,
    parameter int ACC_W   = 32,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*A_W-1:0] req_a;
    logic [NUM_REQ*B_W-1:0] req_b;
    logic [NUM_REQ-1:0]     req_last;
    logic [NUM_REQ-1:0]     req_ready;
    logic [A_W-1:0]         mul_a;
    logic [B_W-1:0]         mul_b;
    logic [P_W-1:0]         mul_p;
    logic                   res_valid;
    logic                   res_ready;
    logic [ACC_W-1:0]       res_data;
    logic [ID_W-1:0]        res_id;
    logic                   busy;

    modport master (
        output req_valid, req_a, req_b, req_last, res_ready, mul_p,
        input  req_ready, mul_a, mul_b, res_valid, res_data, res_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_last, res_ready, mul_p,
        output req_ready, mul_a, mul_b, res_valid, res_data, res_id, busy
    );
endinterface

// File: rtl/cnn_mac_rr_sched.sv
// Round-robin scheduler sharing one external signed multiplier among NUM_REQ dot-product
// requesters, with one private accumulator per requester and a tagged result register.
module cnn_mac_rr_sched #(
    parameter int NUM_REQ = 4,
    parameter int A_W     = 14,
    parameter int B_W     = 7,
    parameter int P_W     = 21,
    parameter int ACC_W   = 32,
    parameter int ID_W    = 2
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    cnn_mac_rr_sched_if.slave  bus
);
    logic [ID_W-1:0]               rr_ptr;
    logic                          s1_valid;
    logic                          s1_last;
    logic [A_W-1:0]                s1_a;
    logic [B_W-1:0]                s1_b;
    logic [ID_W-1:0]               s1_id;
    logic [NUM_REQ-1:0][ACC_W-1:0] acc;
    logic [NUM_REQ-1:0]            open_q;
    logic                          res_valid_q;
    logic [ACC_W-1:0]              res_data_q;
    logic [ID_W-1:0]               res_id_q;

    logic                          stall;
    logic                          adv;
    logic                          accept;
    logic                          do_acc;
    logic [NUM_REQ-1:0]            grant;
    logic [ID_W-1:0]               gnt_id;
    logic [ID_W-1:0]               next_ptr;
    logic [A_W-1:0]                gnt_a;
    logic [B_W-1:0]                gnt_b;
    logic                          gnt_last;
    logic [ACC_W-1:0]              sum;

    assign stall  = s1_valid & s1_last & res_valid_q & ~bus.res_ready;
    assign adv    = ~s1_valid | ~stall;
    assign do_acc = s1_valid & ~stall;
    assign accept = |grant;

    // Two passes give a rotating priority with constant indices: first j >= rr_ptr, then the wrap.
    always_comb begin
        grant    = '0;
        gnt_id   = '0;
        gnt_a    = '0;
        gnt_b    = '0;
        gnt_last = 1'b0;
        if (adv && ap_rst_n) begin
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (grant == '0 && bus.req_valid[j] && j >= 32'(rr_ptr)) begin
                    grant[j] = 1'b1;
                    gnt_id   = ID_W'(j);
                    gnt_a    = bus.req_a[j*A_W +: A_W];
                    gnt_b    = bus.req_b[j*B_W +: B_W];
                    gnt_last = bus.req_last[j];
                end
            end
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (grant == '0 && bus.req_valid[j] && j < 32'(rr_ptr)) begin
                    grant[j] = 1'b1;
                    gnt_id   = ID_W'(j);
                    gnt_a    = bus.req_a[j*A_W +: A_W];
                    gnt_b    = bus.req_b[j*B_W +: B_W];
                    gnt_last = bus.req_last[j];
                end
            end
        end
    end

    always_comb begin
        next_ptr = gnt_id + 1'b1;
        if (gnt_id == ID_W'(NUM_REQ - 1)) begin
            next_ptr = '0;
        end
    end

    assign sum = acc[s1_id] + {{(ACC_W-P_W){bus.mul_p[P_W-1]}}, bus.mul_p};

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rr_ptr      <= '0;
            s1_valid    <= 1'b0;
            s1_last     <= 1'b0;
            s1_a        <= '0;
            s1_b        <= '0;
            s1_id       <= '0;
            acc         <= '0;
            open_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
        end else begin
            if (accept) begin
                rr_ptr   <= next_ptr;
                s1_valid <= 1'b1;
                s1_a     <= gnt_a;
                s1_b     <= gnt_b;
                s1_id    <= gnt_id;
                s1_last  <= gnt_last;
            end else if (adv) begin
                s1_valid <= 1'b0;
            end

            if (do_acc) begin
                if (s1_last) begin
                    res_data_q     <= sum;
                    res_id_q       <= s1_id;
                    acc[s1_id]     <= '0;
                    open_q[s1_id]  <= 1'b0;
                end else begin
                    acc[s1_id]     <= sum;
                    open_q[s1_id]  <= 1'b1;
                end
            end

            // A new load wins over the consumer's accept, so back-to-back results keep res_valid high.
            if (do_acc && s1_last) begin
                res_valid_q <= 1'b1;
            end else if (res_valid_q && bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.mul_a     = s1_a;
    assign bus.mul_b     = s1_b;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
    assign bus.busy      = s1_valid | res_valid_q | (|open_q);
endmodule

// File: doc/cnn_mac_rr_sched.md
Name: cnn_mac_rr_sched

Overview:
- Time-shares one external 14s x 7s combinational multiplier (21-bit product) between NUM_REQ convolution requesters.
- Each requester streams signed operand pairs with a last flag; the block keeps one private accumulator per requester.
- On each requester's last beat it emits that requester's dot product, tagged with its ID.
- Sits between conv PE lanes and the shared DSP48 multiplier instance in the conv layer.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
A_W, 14, signed width of operand a
B_W, 7, signed width of operand b
P_W, 21, signed product width (A_W+B_W)
ACC_W, 32, signed accumulator/result width
ID_W, 2, result tag width, clog2(NUM_REQ)

Ports:
ap_clk  in  1  clock, rising edge
ap_rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester beat valid
req_a  in  NUM_REQ*A_W  packed operand a, requester i at [i*A_W +: A_W]
req_b  in  NUM_REQ*B_W  packed operand b, requester i at [i*B_W +: B_W]
req_last  in  NUM_REQ  final beat of the requester's dot product
req_ready  out  NUM_REQ  one-hot grant; beat accepted when valid & ready
mul_a  out  A_W  operand a to the shared multiplier
mul_b  out  B_W  operand b to the shared multiplier
mul_p  in  P_W  signed product, combinational from mul_a/mul_b
res_valid  out  1  result valid
res_ready  in  1  result consumer ready
res_data  out  ACC_W  signed dot product
res_id  out  ID_W  requester index of res_data
busy  out  1  any beat in flight, result pending, or requester mid-stream

Behaviour:
Reset (async, ap_rst_n=0): everything cleared.
- Outputs: req_ready=0, mul_a=0, mul_b=0, res_valid=0, res_data=0, res_id=0, busy=0.
- Internal state: all accumulators=0, open flags=0, RR pointer=0, s1_valid=0.
- Deassertion mid-operation: partial sums are lost; beats are not replayed.

Arbitration (stage 0, combinational):
- Search starts at the RR pointer, then increments modulo NUM_REQ.
- The first i with req_valid[i]=1 gets req_ready[i]=1; at most one bit is set.
- Grant is issued only if adv=1.
- adv = !s1_valid | !stall.
- stall = s1_valid & s1_last & res_valid & !res_ready.
- On an accepted beat from requester i, the pointer becomes (i+1) mod NUM_REQ; otherwise it holds.
- req_ready may depend combinationally on req_valid; requesters must not make req_valid depend on req_ready.

Stage 1 (register):
- On an accepted beat, capture a, b, id, last into s1 and set s1_valid.
- If adv and no accept, clear s1_valid.
- mul_a/mul_b are driven directly from the s1 operand registers. They hold their last value when s1_valid=0 (no toggling).

Stage 2 (accumulate), on s1_valid & !stall:
- sum = acc[s1_id] + sign_extend(mul_p, ACC_W), two's-complement wrap, no saturation.
- If s1_last=0: acc[s1_id] <= sum; open[s1_id] <= 1.
- If s1_last=1: res_data <= sum; res_id <= s1_id; res_valid <= 1; acc[s1_id] <= 0; open[s1_id] <= 0.
- A single-beat stream (last on the first beat) yields a*b.

Result register:
- Cleared by res_valid & res_ready.
- A load and an accept in the same cycle is legal: the old result leaves and the new one loads, so res_valid stays 1.
- A non-last beat never stalls.
- While stalled, s1 and mul_a/mul_b hold, and all req_ready=0.

Latency and throughput:
- Beat accepted at edge E0; product accumulated at E1.
- For a last beat, res_valid=1 after E1, i.e. 2 cycles from handshake to result.
- Throughput: 1 beat/cycle across all requesters when res_ready=1.
- Interleaving beats of different requesters is legal because accumulators are per-requester.

busy = s1_valid | res_valid | (|open).

Test Plan:
- Single stream, ch0 beats (100,3), (-200,-5), (8191,-64,last), res_ready=1 -> one result res_data=-522924, res_id=0, res_valid exactly 2 cycles after the last handshake, then busy=0.
- All 4 req_valid held high, single-beat streams (a=i+1, b=2) -> grants cycle 0,1,2,3,0,...; results 2,4,6,8 in grant order at 1 result/cycle.
- res_ready=0; ch1 then ch2 send last beats (10,10),(−3,7) -> res_data=100,id=1 holds; ch2 beat stalls in s1 with mul_a=-3 stable and all req_ready=0; raising res_ready for 1 cycle accepts 100 and loads -21,id=2 with res_valid staying high.
- Interleaved ch0/ch3 streams, 3 beats each with random operands -> each result equals its own reference dot product; the other channel's accumulator is unaffected.
- Extremes: 4096 beats of (-8192,-64) on ch2 then last (0,0) -> res_data=-2147483648 (wrap from 2^31).
- Assert ap_rst_n low mid-stream on ch0 (after 2 beats), release, send (5,5,last) -> res_data=25 (no stale partial sum); all outputs 0 during reset.
